// File: rtl/clkdiv_slip_ctrl.sv
// clkdiv_slip_ctrl: holds an ICB_CLKDIV divider in reset until PLL lock, then phase-aligns it with BIT_SLIP pulses.
// Define CLKDIV_SLIP_CTRL_WDOG_EN to add the loss-of-alignment watchdog in LOCKED.
module clkdiv_slip_ctrl #(
    parameter int unsigned RST_HOLD_CYC = 16,
    parameter int unsigned SETTLE_CYC   = 8,
    parameter int unsigned SAMPLE_WIN   = 4,
    parameter int unsigned MAX_SLIP     = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       LOCK,
    input  logic       START,
    input  logic       ALIGN_OK,
    output logic       DIV_RST_N,
    output logic       DIV_BIT_SLIP,
    output logic       BUSY,
    output logic       DONE,
    output logic       FAIL,
    output logic       LOSS,
    output logic [3:0] SLIP_CNT
);

    localparam logic [7:0] HOLD_LAST   = 8'(RST_HOLD_CYC - 1);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [7:0] WIN_LAST    = 8'(SAMPLE_WIN - 1);
    localparam logic [3:0] SLIP_MAX    = 4'(MAX_SLIP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_HOLD,
        S_SETTLE,
        S_CHECK,
        S_SLIP,
        S_LOCKED,
        S_FAIL
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] slip_cnt_q, slip_cnt_d;
    logic       slip_room;

    assign slip_room = (slip_cnt_q < SLIP_MAX);

`ifdef CLKDIV_SLIP_CTRL_WDOG_EN
    logic loss_q, loss_d;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            slip_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            slip_cnt_q <= slip_cnt_d;
        end
    end

`ifdef CLKDIV_SLIP_CTRL_WDOG_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            loss_q <= 1'b0;
        end else begin
            loss_q <= loss_d;
        end
    end
`endif

    // Lock loss overrides everything except reset; START only acts from IDLE, LOCKED and FAIL.
    always_comb begin
        state_d = state_q;
`ifdef CLKDIV_SLIP_CTRL_WDOG_EN
        loss_d  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (START && LOCK) begin
                    state_d = S_RST_HOLD;
                end
            end
            S_RST_HOLD: begin
                if (!LOCK) begin
                    state_d = S_IDLE;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (!LOCK) begin
                    state_d = S_IDLE;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!LOCK) begin
                    state_d = S_IDLE;
                end else if (!ALIGN_OK) begin
                    state_d = slip_room ? S_SLIP : S_FAIL;
                end else if (cnt_q == WIN_LAST) begin
                    state_d = S_LOCKED;
                end
            end
            S_SLIP: begin
                state_d = LOCK ? S_SETTLE : S_IDLE;
            end
            S_LOCKED: begin
                if (!LOCK) begin
                    state_d = S_IDLE;
                end else if (START) begin
                    state_d = S_RST_HOLD;
                end
`ifdef CLKDIV_SLIP_CTRL_WDOG_EN
                else if (!ALIGN_OK && (cnt_q == WIN_LAST)) begin
                    state_d = slip_room ? S_SLIP : S_FAIL;
                    loss_d  = 1'b1;
                end
`endif
            end
            S_FAIL: begin
                if (!LOCK) begin
                    state_d = S_IDLE;
                end else if (START) begin
                    state_d = S_RST_HOLD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // One shared counter: cycles-in-state for timed states, consecutive-zero run in LOCKED.
    always_comb begin
        cnt_d = '0;
        if (state_d == state_q) begin
            case (state_q)
                S_RST_HOLD, S_SETTLE, S_CHECK: cnt_d = cnt_q + 8'd1;
`ifdef CLKDIV_SLIP_CTRL_WDOG_EN
                S_LOCKED:                      cnt_d = ALIGN_OK ? 8'd0 : cnt_q + 8'd1;
`endif
                default:                       cnt_d = '0;
            endcase
        end
    end

    always_comb begin
        slip_cnt_d = slip_cnt_q;
        if ((state_d == S_RST_HOLD) && (state_q != S_RST_HOLD)) begin
            slip_cnt_d = '0;
        end else if ((state_q == S_SLIP) && slip_room) begin
            slip_cnt_d = slip_cnt_q + 4'd1;
        end
    end

    assign DIV_RST_N    = (state_q != S_IDLE) && (state_q != S_RST_HOLD);
    assign DIV_BIT_SLIP = (state_q == S_SLIP);
    assign BUSY         = (state_q == S_RST_HOLD) || (state_q == S_SETTLE) ||
                          (state_q == S_CHECK)    || (state_q == S_SLIP);
    assign DONE         = (state_q == S_LOCKED);
    assign FAIL         = (state_q == S_FAIL);
    assign SLIP_CNT     = slip_cnt_q;

`ifdef CLKDIV_SLIP_CTRL_WDOG_EN
    assign LOSS = loss_q;
`else
    assign LOSS = 1'b0;
`endif

endmodule

// File: tb/tb_clkdiv_slip_ctrl.sv
// Directed and randomized checks of clkdiv_slip_ctrl against a phase/countdown reference model.
module tb_clkdiv_slip_ctrl;

    localparam int unsigned R = 16;
    localparam int unsigned S = 8;
    localparam int unsigned W = 4;
    localparam int unsigned M = 4;

    logic       CLK = 1'b0;
    logic       RESET, LOCK, START, ALIGN_OK;
    logic       DIV_RST_N, DIV_BIT_SLIP, BUSY, DONE, FAIL, LOSS;
    logic [3:0] SLIP_CNT;

    always #5 CLK = ~CLK;

    clkdiv_slip_ctrl #(
        .RST_HOLD_CYC(R),
        .SETTLE_CYC  (S),
        .SAMPLE_WIN  (W),
        .MAX_SLIP    (M)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .LOCK        (LOCK),
        .START       (START),
        .ALIGN_OK    (ALIGN_OK),
        .DIV_RST_N   (DIV_RST_N),
        .DIV_BIT_SLIP(DIV_BIT_SLIP),
        .BUSY        (BUSY),
        .DONE        (DONE),
        .FAIL        (FAIL),
        .LOSS        (LOSS),
        .SLIP_CNT    (SLIP_CNT)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: phase plus remaining-cycle countdown and run lengths.
    typedef enum {P_IDLE, P_HOLD, P_SETTLE, P_CHECK, P_SLIP, P_LOCKED, P_FAILED} phase_t;
    phase_t m_phase = P_IDLE;
    int     m_left  = 0;
    int     m_ones  = 0;
    int     m_zeros = 0;
    int     m_slips = 0;
    bit     m_loss  = 0;

    task automatic enter_hold();
        m_phase = P_HOLD;
        m_left  = R;
        m_slips = 0;
    endtask

    task automatic model_step(input logic r, input logic l, input logic s, input logic a);
        bit loss_n;
        loss_n = 0;
        if (r) begin
            m_phase = P_IDLE;
            m_slips = 0;
            m_loss  = 0;
            return;
        end
        if (m_phase == P_SLIP && m_slips < M) m_slips++;
        if (m_phase == P_IDLE) begin
            if (s && l) enter_hold();
        end else if (!l) begin
            m_phase = P_IDLE;
        end else begin
            case (m_phase)
                P_HOLD: begin
                    m_left--;
                    if (m_left == 0) begin m_phase = P_SETTLE; m_left = S; end
                end
                P_SETTLE: begin
                    m_left--;
                    if (m_left == 0) begin m_phase = P_CHECK; m_ones = 0; end
                end
                P_CHECK: begin
                    if (a) begin
                        m_ones++;
                        if (m_ones == W) begin m_phase = P_LOCKED; m_zeros = 0; end
                    end else begin
                        m_phase = (m_slips < M) ? P_SLIP : P_FAILED;
                    end
                end
                P_SLIP: begin
                    m_phase = P_SETTLE;
                    m_left  = S;
                end
                P_LOCKED: begin
                    if (s) begin
                        enter_hold();
                    end else begin
`ifdef CLKDIV_SLIP_CTRL_WDOG_EN
                        m_zeros = a ? 0 : m_zeros + 1;
                        if (m_zeros == W) begin
                            loss_n  = 1;
                            m_phase = (m_slips < M) ? P_SLIP : P_FAILED;
                        end
`endif
                    end
                end
                P_FAILED: begin
                    if (s) enter_hold();
                end
                default: m_phase = P_IDLE;
            endcase
        end
        m_loss = loss_n;
    endtask

    // Scenario bookkeeping; cycle numbers follow "START sampled at edge 0".
    int t = 0;
    int first_rstn, first_done, n_slip, n_loss;
    int slip_cyc[$];

    task automatic begin_scn();
        t = 0;
        first_rstn = 0;
        first_done = 0;
        n_slip = 0;
        n_loss = 0;
        slip_cyc.delete();
    endtask

    task automatic tick(input logic r, input logic l, input logic s, input logic a);
        int cyc;
        RESET = r; LOCK = l; START = s; ALIGN_OK = a;
        @(posedge CLK);
        model_step(r, l, s, a);
        #1;
        chk("rst_n",    DIV_RST_N,    (m_phase != P_IDLE && m_phase != P_HOLD));
        chk("bit_slip", DIV_BIT_SLIP, (m_phase == P_SLIP));
        chk("busy",     BUSY,         (m_phase inside {P_HOLD, P_SETTLE, P_CHECK, P_SLIP}));
        chk("done",     DONE,         (m_phase == P_LOCKED));
        chk("fail_flag", FAIL,        (m_phase == P_FAILED));
        chk("loss",     LOSS,         m_loss);
        chk("slip_cnt", SLIP_CNT,     m_slips);
        cyc = t + 1;
        if (DIV_RST_N === 1'b1 && first_rstn == 0) first_rstn = cyc;
        if (DONE === 1'b1 && first_done == 0) first_done = cyc;
        if (DIV_BIT_SLIP === 1'b1) begin n_slip++; slip_cyc.push_back(cyc); end
        if (LOSS === 1'b1) n_loss++;
        t++;
    endtask

    initial begin
        int align_pct;
        logic r, l, s, a;

        // Reset values
        tick(1, 1, 0, 0);
        tick(1, 1, 0, 0);
        chk("rst_rst_n", DIV_RST_N, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_slip_cnt", SLIP_CNT, 0);

        // Aligned first try; a START during BUSY must not restart the hold
        begin_scn();
        tick(0, 1, 1, 1);
        for (int i = 1; i < 40; i++) tick(0, 1, (i == 10), 1);
        chk("a_rstn_rise", first_rstn, R + 1);
        chk("a_done_rise", first_done, R + S + W + 1);
        chk("a_slips", n_slip, 0);
        chk("a_slip_cnt", SLIP_CNT, 0);

        // Two slips, ALIGN_OK=0 before cycle 45
        begin_scn();
        tick(0, 1, 1, 0);
        for (int i = 1; i < 60; i++) tick(0, 1, 0, (i >= 45));
        chk("b_slips", n_slip, 2);
        chk("b_slip0", (slip_cyc.size() > 0) ? slip_cyc[0] : 0, 26);
        chk("b_slip1", (slip_cyc.size() > 1) ? slip_cyc[1] : 0, 36);
        chk("b_done_rise", first_done, 49);
        chk("b_slip_cnt", SLIP_CNT, 2);

        // Budget exhausted -> FAIL, then restart clears SLIP_CNT
        begin_scn();
        tick(0, 1, 1, 0);
        for (int i = 1; i < 75; i++) tick(0, 1, 0, 0);
        chk("c_slips", n_slip, M);
        chk("c_fail_flag", FAIL, 1);
        chk("c_done", DONE, 0);
        chk("c_slip_cnt", SLIP_CNT, M);
        chk("c_rst_n", DIV_RST_N, 1);
        tick(0, 1, 1, 0);
        chk("c_restart_cnt", SLIP_CNT, 0);
        chk("c_restart_busy", BUSY, 1);
        chk("c_restart_rstn", DIV_RST_N, 0);

        // LOCK drop during SETTLE; START with LOCK=0 ignored
        tick(0, 0, 0, 0);
        tick(0, 0, 1, 1);
        chk("d_nolock_start", BUSY, 0);
        begin_scn();
        tick(0, 1, 1, 1);
        for (int i = 1; i < 19; i++) tick(0, 1, 0, 1);
        chk("d_settle_busy", BUSY, 1);
        tick(0, 0, 0, 1);
        chk("d_drop_rstn", DIV_RST_N, 0);
        chk("d_drop_busy", BUSY, 0);

        // RESET during CHECK
        begin_scn();
        tick(0, 1, 1, 1);
        for (int i = 1; i < 25; i++) tick(0, 1, 0, 1);
        chk("e_in_check_busy", BUSY, 1);
        tick(1, 1, 0, 1);
        chk("e_rst_n", DIV_RST_N, 0);
        chk("e_busy", BUSY, 0);
        chk("e_done", DONE, 0);
        chk("e_bit_slip", DIV_BIT_SLIP, 0);
        chk("e_fail_flag", FAIL, 0);
        chk("e_loss", LOSS, 0);
        chk("e_slip_cnt", SLIP_CNT, 0);

        // Misalignment in LOCKED for SAMPLE_WIN cycles
        begin_scn();
        tick(0, 1, 1, 1);
        for (int i = 1; i < 60; i++) tick(0, 1, 0, !(i >= 30 && i < 34));
`ifdef CLKDIV_SLIP_CTRL_WDOG_EN
        chk("f_loss_pulses", n_loss, 1);
        chk("f_slips", n_slip, 1);
        chk("f_slip_cnt", SLIP_CNT, 1);
`else
        chk("f_loss_pulses", n_loss, 0);
        chk("f_slips", n_slip, 0);
        chk("f_slip_cnt", SLIP_CNT, 0);
`endif
        chk("f_done_end", DONE, 1);

        // Randomized traffic against the model
        align_pct = 100;
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) align_pct = $urandom_range(50, 100);
            r = ($urandom_range(0, 299) == 0);
            l = ($urandom_range(0, 149) != 0);
            s = ($urandom_range(0, 39) == 0);
            a = ($urandom_range(1, 100) <= align_pct);
            tick(r, l, s, a);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/clkdiv_slip_ctrl.md
# clkdiv_slip_ctrl

Sequencing controller for a fabric clock-divider macro (ICB_CLKDIV class). It holds the divider in reset until the PLL reports lock, then releases it. It then aligns the divided clock's phase by issuing single-cycle BIT_SLIP pulses until an external phase detector reports alignment, or until a slip budget is exhausted. It sits beside the divider instance in each video clock-generation subsystem and drives the divider's RST_N and BIT_SLIP pins directly.

## Interface
- RST_HOLD_CYC, 16: cycles DIV_RST_N is held low after START (1..255)
- SETTLE_CYC, 8: cycles waited after reset release or after a slip, before sampling (1..255)
- SAMPLE_WIN, 4: consecutive ALIGN_OK=1 samples needed to declare alignment (1..15)
- MAX_SLIP, 4: slip budget before FAIL (1..15)

Ports:
- CLK  in  1  divider source clock; all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- LOCK  in  1  PLL lock, already synchronous to CLK
- START  in  1  single-cycle request to (re)align
- ALIGN_OK  in  1  phase-detector result, synchronous to CLK
- DIV_RST_N  out  1  to divider RST_N
- DIV_BIT_SLIP  out  1  to divider BIT_SLIP; one-cycle pulse per slip
- BUSY  out  1  high in RST_HOLD, SETTLE, CHECK, SLIP
- DONE  out  1  high in LOCKED
- FAIL  out  1  high in FAIL
- LOSS  out  1  one-cycle pulse on watchdog loss-of-alignment
- SLIP_CNT  out  4  slips issued in the current alignment attempt

## Operation
- The FSM has 7 states: IDLE, RST_HOLD, SETTLE, CHECK, SLIP, LOCKED, FAIL.
- Outputs are Moore outputs decoded from registered state. DIV_RST_N is 0 only in IDLE and RST_HOLD.
- IDLE: on START=1 with LOCK=1, go to RST_HOLD. START with LOCK=0 is ignored.
- RST_HOLD: entry clears SLIP_CNT. The state lasts exactly RST_HOLD_CYC cycles, then goes to SETTLE.
- SETTLE: lasts exactly SETTLE_CYC cycles, then goes to CHECK.
- CHECK: samples ALIGN_OK each cycle.
  - SAMPLE_WIN consecutive 1s: go to LOCKED.
  - First 0 with SLIP_CNT<MAX_SLIP: go to SLIP the next cycle.
  - First 0 with SLIP_CNT==MAX_SLIP: go to FAIL.
- SLIP: lasts one cycle. DIV_BIT_SLIP=1 and SLIP_CNT increments. Then go to SETTLE.
- LOCKED and FAIL: hold until START (go to RST_HOLD) or LOCK=0.
- Priority: RESET > LOCK=0 > START > normal flow.
  - LOCK=0 in any non-IDLE state forces IDLE on the next cycle, and DIV_RST_N goes low.
  - SLIP_CNT holds its value in IDLE, LOCKED and FAIL.
- START while BUSY is ignored.
- Cycle and sample counters are reloaded on every state entry. SLIP_CNT saturates at MAX_SLIP.

## Timing
- Reset values: DIV_RST_N=0, DIV_BIT_SLIP=0, BUSY=0, DONE=0, FAIL=0, LOSS=0, SLIP_CNT=0, state IDLE.
- Latency from START sampled at edge k (R=RST_HOLD_CYC, S=SETTLE_CYC, W=SAMPLE_WIN):
  - RST_HOLD spans cycles k+1..k+R.
  - DIV_RST_N=1 from k+R+1.
  - CHECK spans k+R+S+1..k+R+S+W.
  - DONE=1 from k+R+S+W+1 when aligned first try.
- Each slip costs 1+S cycles before CHECK resumes.
- Worst case to FAIL: R + MAX_SLIP·(1+S) + S + W, plus the failing-sample cycles.

## Configuration
- The only compile-time option is the macro CLKDIV_SLIP_CTRL_WDOG_EN.
- Defined: in LOCKED, a watchdog counts consecutive ALIGN_OK=0 cycles.
  - At SAMPLE_WIN, LOSS pulses for one cycle and DONE drops.
  - The FSM then goes to SLIP if SLIP_CNT<MAX_SLIP, else to FAIL.
  - The count resets on any ALIGN_OK=1.
- Undefined: ALIGN_OK is ignored in LOCKED, LOSS is tied 0, and no watchdog logic is generated.

## Test plan
- Defaults, LOCK=1, START at cycle 0, ALIGN_OK=1 → DIV_RST_N rises cycle 17, DONE=1 cycle 29, SLIP_CNT=0, no DIV_BIT_SLIP pulse.
- ALIGN_OK=0 until cycle 45 → DIV_BIT_SLIP pulses at cycles 26 and 36 only, DONE=1 cycle 49, SLIP_CNT=2.
- ALIGN_OK always 0 → exactly 4 slip pulses, then FAIL=1, DONE=0, SLIP_CNT=4, DIV_RST_N stays 1; a later START → RST_HOLD with SLIP_CNT=0.
- LOCK drops during SETTLE → next cycle IDLE, DIV_RST_N=0, BUSY=0. START during BUSY and START with LOCK=0 are both ignored.
- RESET asserted during CHECK → next cycle every output equals its reset value.
- With CLKDIV_SLIP_CTRL_WDOG_EN and LOCKED, ALIGN_OK=0 for 4 cycles → LOSS pulse, DONE=0, one slip, realign. Without the macro → DONE stays 1 and LOSS stays 0.
